// File: rtl/mips_boot_pkg.sv
// Shared constants and state type for the MIPS byte-stream boot loader.
// Command bytes select imem load, dmem load or a timed CPU run.
package mips_boot_pkg;

  localparam logic [7:0] CMD_IMEM = 8'h49;
  localparam logic [7:0] CMD_DMEM = 8'h44;
  localparam logic [7:0] CMD_GO   = 8'h47;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_ADDR,
    S_HDR_LEN,
    S_DATA,
    S_GO_PC,
    S_GO_CYC,
    S_RUN,
    S_ERR
  } boot_state_t;

endpackage

// File: rtl/mips_boot_field_shift.sv
// Big-endian field accumulator: shifts bytes in MSB-first.
// o_done flags the byte that completes the field; o_next is its value.
module mips_boot_field_shift #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic [7:0]            i_byte,
  output logic [8*NBYTES-1:0]   o_next,
  output logic                  o_done
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES + 1);

  logic [W-1:0]  r_val;
  logic [CW-1:0] r_cnt;

  assign o_next = (r_val << 8) | W'(i_byte);
  assign o_done = i_en && (r_cnt == CW'(NBYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_val <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      r_val <= o_next;
      r_cnt <= o_done ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mips_boot_loader.sv
// Framed byte-stream loader: writes imem/dmem byte-by-byte, then
// releases the CPU from reset at a chosen PC for a counted run.
module mips_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int ADDR_BYTES = 4,
  parameter int LEN_BYTES  = 2,
  parameter int CYC_BYTES  = 4,
  parameter int IMEM_SIZE  = 256,
  parameter int DMEM_SIZE  = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_data,
  output logic                    imem_we,
  output logic                    dmem_we,
  output logic [8*ADDR_BYTES-1:0] mem_addr,
  output logic [7:0]              mem_wdata,
  output logic                    pc_load,
  output logic [8*ADDR_BYTES-1:0] pc_init,
  output logic                    cpu_rst_n,
  output logic                    run_done,
  output logic                    err,
  output logic                    busy
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int LW = 8 * LEN_BYTES;
  localparam int CW = 8 * CYC_BYTES;

  boot_state_t r_state, w_next;

  logic          w_acc;
  logic          w_clr;
  logic          w_addr_en;
  logic [AW-1:0] w_addr_next;
  logic          w_addr_done;
  logic [LW-1:0] w_len_next;
  logic          w_len_done;
  logic [CW-1:0] w_cyc_next;
  logic          w_cyc_done;
  logic          w_oor;
  logic          w_is_ld;
  logic          w_is_go;

  logic          r_tgt_d;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_rem;
  logic [CW-1:0] r_cnt;
  logic          r_cpu_run;
  logic          r_we_i;
  logic          r_we_d;
  logic          r_pc_load;
  logic          r_done;
  logic [AW-1:0] r_maddr;
  logic [AW-1:0] r_pc_init;
  logic [7:0]    r_wdata;

  assign in_ready = (r_state != S_RUN) && (r_state != S_ERR);
  assign busy     = (r_state != S_IDLE);
  assign err      = (r_state == S_ERR);
  assign w_acc    = in_valid && in_ready;
  assign w_clr    = (r_state == S_IDLE);
  assign w_is_ld  = (in_data == CMD_IMEM) || (in_data == CMD_DMEM);
  assign w_is_go  = (in_data == CMD_GO);
  assign w_addr_en = w_acc &&
                     ((r_state == S_HDR_ADDR) || (r_state == S_GO_PC));
  assign w_oor = r_tgt_d ? (r_addr >= AW'(DMEM_SIZE))
                         : (r_addr >= AW'(IMEM_SIZE));

  assign imem_we   = r_we_i;
  assign dmem_we   = r_we_d;
  assign mem_addr  = r_maddr;
  assign mem_wdata = r_wdata;
  assign pc_load   = r_pc_load;
  assign pc_init   = r_pc_init;
  assign cpu_rst_n = r_cpu_run;
  assign run_done  = r_done;

  // Address and PC never overlap in time, so they share one shifter.
  mips_boot_field_shift #(.NBYTES(ADDR_BYTES)) u_addr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_en   (w_addr_en),
    .i_byte (in_data),
    .o_next (w_addr_next),
    .o_done (w_addr_done)
  );

  mips_boot_field_shift #(.NBYTES(LEN_BYTES)) u_len (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_en   (w_acc && (r_state == S_HDR_LEN)),
    .i_byte (in_data),
    .o_next (w_len_next),
    .o_done (w_len_done)
  );

  mips_boot_field_shift #(.NBYTES(CYC_BYTES)) u_cyc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_en   (w_acc && (r_state == S_GO_CYC)),
    .i_byte (in_data),
    .o_next (w_cyc_next),
    .o_done (w_cyc_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          unique case (1'b1)
            w_is_ld: w_next = S_HDR_ADDR;
            w_is_go: w_next = S_GO_PC;
            default: w_next = S_ERR;
          endcase
        end
      end
      S_HDR_ADDR: if (w_addr_done) w_next = S_HDR_LEN;
      S_HDR_LEN: begin
        if (w_len_done)
          w_next = (w_len_next == '0) ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_acc) begin
          if (w_oor)                 w_next = S_ERR;
          else if (r_rem == LW'(1))  w_next = S_IDLE;
        end
      end
      S_GO_PC: if (w_addr_done) w_next = S_GO_CYC;
      S_GO_CYC: begin
        if (w_cyc_done)
          w_next = (w_cyc_next == '0) ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (!r_pc_load && r_cpu_run && (r_cnt == CW'(1)))
          w_next = S_IDLE;
      end
      S_ERR:   w_next = S_ERR;
      default: w_next = S_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tgt_d   <= 1'b0;
      r_addr    <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_cpu_run <= 1'b0;
      r_we_i    <= 1'b0;
      r_we_d    <= 1'b0;
      r_pc_load <= 1'b0;
      r_done    <= 1'b0;
      r_maddr   <= '0;
      r_pc_init <= '0;
      r_wdata   <= '0;
    end else begin
      r_we_i    <= 1'b0;
      r_we_d    <= 1'b0;
      r_pc_load <= 1'b0;
      r_done    <= 1'b0;
      unique case (r_state)
        S_IDLE: if (w_acc) r_tgt_d <= (in_data == CMD_DMEM);
        S_HDR_ADDR: if (w_addr_done) r_addr <= w_addr_next;
        S_HDR_LEN: if (w_len_done) r_rem <= w_len_next;
        S_DATA: begin
          if (w_acc) begin
            r_maddr <= r_addr;
            r_wdata <= in_data;
            if (!w_oor) begin
              r_we_i <= !r_tgt_d;
              r_we_d <= r_tgt_d;
            end
            r_addr <= r_addr + AW'(1);
            r_rem  <= r_rem - LW'(1);
          end
        end
        S_GO_PC: if (w_addr_done) r_addr <= w_addr_next;
        S_GO_CYC: begin
          if (w_cyc_done) begin
            if (w_cyc_next == '0) begin
              r_done <= 1'b1;
            end else begin
              r_pc_load <= 1'b1;
              r_pc_init <= r_addr;
              r_cnt     <= w_cyc_next;
            end
          end
        end
        // First RUN cycle is the pc_load cycle; CPU runs from the next one.
        S_RUN: begin
          if (r_pc_load) begin
            r_cpu_run <= 1'b1;
          end else if (r_cpu_run) begin
            if (r_cnt == CW'(1)) begin
              r_cpu_run <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
        end
        S_ERR: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Self-checking bench for mips_boot_loader: table vectors, random
// frames against a frame-level reference model, and corner sequences.
module tb_mips_boot_loader;

  localparam int IMSZ = 256;
  localparam int DMSZ = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, imem_we, dmem_we, pc_load;
  logic        cpu_rst_n, run_done, err, busy;
  logic [31:0] mem_addr, pc_init;
  logic [7:0]  mem_wdata;

  always #5 clk = ~clk;

  mips_boot_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .imem_we   (imem_we),
    .dmem_we   (dmem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .pc_load   (pc_load),
    .pc_init   (pc_init),
    .cpu_rst_n (cpu_rst_n),
    .run_done  (run_done),
    .err       (err),
    .busy      (busy)
  );

  typedef struct packed {
    logic        d;
    logic [31:0] a;
    logic [7:0]  v;
  } wr_t;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    int          len;
    logic [31:0] data;
    int          gap;
    int          exp_nw;
    bit          exp_err;
  } vec_t;

  wr_t         wq[$];
  logic [7:0]  fq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_hi = 0, n_pcl = 0, n_done = 0, n_fall = 0;
  int          n_rise = 0, n_both = 0, n_rdy_bad = 0;
  logic [31:0] last_pc = '0;
  bit          prev_hi = 0, prev_pcl = 0;
  int          gap_mode = 0;
  bit          ph = 0;

  always @(negedge clk) begin
    if (imem_we || dmem_we) wq.push_back({dmem_we, mem_addr, mem_wdata});
    if (imem_we && dmem_we) n_both++;
    if (cpu_rst_n) n_hi++;
    if (cpu_rst_n && in_ready) n_rdy_bad++;
    if (pc_load) begin n_pcl++; last_pc = pc_init; end
    if (cpu_rst_n && !prev_hi && prev_pcl) n_rise++;
    if (run_done) begin
      n_done++;
      if (!cpu_rst_n && prev_hi) n_fall++;
    end
    prev_hi  = cpu_rst_n;
    prev_pcl = pc_load;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push_be(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) fq.push_back(v[8*i +: 8]);
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int t;
    t  = 0;
    ok = 0;
    while (t < 40) begin
      @(negedge clk);
      in_valid = 1'b0;
      t++;
      if (gap_mode == 1) begin
        ph = ~ph;
        if (ph) continue;
      end else if (gap_mode == 2 && $urandom_range(0, 2) == 0) begin
        continue;
      end
      if (in_ready) begin
        in_valid = 1'b1;
        in_data  = b;
        ok       = 1;
        break;
      end
    end
  endtask

  task automatic send_frame(output int nacc);
    bit ok;
    nacc = 0;
    foreach (fq[i]) begin
      send_byte(fq[i], ok);
      if (!ok) break;
      nacc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Frame-level model: which bytes get written, and where it errors.
  task automatic model_load(input logic [7:0] cmd, input logic [31:0] a,
                            input logic [7:0] d[$], output wr_t m[$],
                            output bit e, output int nacc);
    int lim;
    m    = {};
    e    = 0;
    nacc = 7;
    if (cmd != 8'h49 && cmd != 8'h44) begin
      e    = 1;
      nacc = 1;
      return;
    end
    lim = (cmd == 8'h44) ? DMSZ : IMSZ;
    for (int k = 0; k < d.size(); k++) begin
      logic [31:0] ak;
      ak = a + 32'(k);
      nacc++;
      if (ak >= 32'(lim)) begin
        e = 1;
        return;
      end
      m.push_back({cmd == 8'h44, ak, d[k]});
    end
  endtask

  task automatic run_load(input string nm, input logic [7:0] cmd,
                          input logic [31:0] a, input logic [7:0] d[$],
                          output int nw, output bit e_obs);
    wr_t m[$];
    bit  e;
    int  nx, nacc, base;
    base = wq.size();
    fq = {};
    fq.push_back(cmd);
    push_be(a, 4);
    push_be(32'(d.size()), 2);
    foreach (d[k]) fq.push_back(d[k]);
    send_frame(nacc);
    repeat (3) @(negedge clk);
    #1;
    model_load(cmd, a, d, m, e, nx);
    nw = wq.size() - base;
    chk({nm, " accepted"}, 64'(nacc), 64'(nx));
    chk({nm, " nwrites"}, 64'(nw), 64'(m.size()));
    foreach (m[i])
      if (base + i < wq.size())
        chk({nm, " write"}, 64'(wq[base+i]), 64'(m[i]));
    chk({nm, " err"}, 64'(err), 64'(e));
    chk({nm, " in_ready"}, 64'(in_ready), 64'(!e));
    e_obs = err;
  endtask

  task automatic run_go(input string nm, input logic [31:0] pc,
                        input logic [31:0] cyc);
    int b_hi, b_pcl, b_done, b_fall, b_rise, b_rdy, nacc, t;
    b_hi = n_hi; b_pcl = n_pcl; b_done = n_done;
    b_fall = n_fall; b_rise = n_rise; b_rdy = n_rdy_bad;
    fq = {};
    fq.push_back(8'h47);
    push_be(pc, 4);
    push_be(cyc, 4);
    send_frame(nacc);
    #1;
    t = 0;
    while (n_done == b_done && t < int'(cyc) + 30) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk({nm, " done"}, 64'(n_done - b_done), 64'd1);
    chk({nm, " cpu cycles"}, 64'(n_hi - b_hi), 64'(cyc));
    chk({nm, " pc_load"}, 64'(n_pcl - b_pcl), 64'(cyc != 0));
    if (cyc != 0) begin
      chk({nm, " pc_init"}, 64'(last_pc), 64'(pc));
      chk({nm, " done at fall"}, 64'(n_fall - b_fall), 64'd1);
      chk({nm, " rise after load"}, 64'(n_rise - b_rise), 64'd1);
    end
    chk({nm, " ready in run"}, 64'(n_rdy_bad - b_rdy), 64'd0);
    chk({nm, " busy after"}, 64'(busy), 64'd0);
    @(negedge clk);
    #1;
    chk({nm, " done pulse"}, 64'(run_done), 64'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tv[6];

  initial begin
    logic [7:0] dq[$];
    int         nw, len, k, t, b_done;
    bit         eo;
    logic [31:0] a;

    tv[0] = '{8'h49, 32'h00, 4, 32'h0C000005, 0, 4, 0};
    tv[1] = '{8'h44, 32'h04, 4, 32'h00000028, 1, 4, 0};
    tv[2] = '{8'h49, 32'h10, 0, 32'h00000000, 0, 0, 0};
    tv[3] = '{8'h44, 32'hFC, 4, 32'h01020304, 2, 4, 0};
    tv[4] = '{8'h49, 32'h80, 3, 32'hDEADBE00, 2, 3, 0};
    tv[5] = '{8'h44, 32'hFF, 1, 32'h5A000000, 1, 1, 0};

    repeat (2) @(negedge clk);
    #1;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    chk("rst cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    chk("rst strobes", 64'({imem_we, dmem_we, pc_load, run_done}), 64'd0);
    chk("rst pc_init", 64'(pc_init), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      dq = {};
      for (int j = 0; j < tv[i].len; j++) dq.push_back(tv[i].data[31-8*j -: 8]);
      gap_mode = tv[i].gap;
      run_load($sformatf("vec%0d", i), tv[i].cmd, tv[i].addr, dq, nw, eo);
      chk($sformatf("vec%0d table nw", i), 64'(nw), 64'(tv[i].exp_nw));
      chk($sformatf("vec%0d table err", i), 64'(eo), 64'(tv[i].exp_err));
      chk($sformatf("vec%0d idle", i), 64'(busy), 64'd0);
    end

    gap_mode = 0;
    run_go("go30", 32'h0, 32'd30);
    run_go("go0", 32'h1234, 32'd0);
    gap_mode = 2;
    run_go("go1", 32'h00400000, 32'd1);

    for (int r = 0; r < 25; r++) begin
      gap_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) begin
        run_go($sformatf("rgo%0d", r), $urandom, $urandom_range(0, 12));
      end else begin
        len = $urandom_range(0, 8);
        if ($urandom_range(0, 4) == 0) a = 32'(256 - len);
        else a = 32'($urandom_range(0, 256 - len));
        dq = {};
        for (int j = 0; j < len; j++) dq.push_back(8'($urandom_range(0, 255)));
        run_load($sformatf("rld%0d", r),
                 ($urandom_range(0, 1) == 1) ? 8'h49 : 8'h44, a, dq, nw, eo);
      end
    end

    gap_mode = 0;
    b_done = n_done;
    fq = {};
    fq.push_back(8'h47);
    push_be(32'h0, 4);
    push_be(32'd30, 4);
    send_frame(t);
    k = 0;
    t = 0;
    while (k < 10 && t < 100) begin
      @(negedge clk);
      t++;
      if (cpu_rst_n) k++;
    end
    chk("midrun cpu high", 64'(cpu_rst_n), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun cpu_rst_n drop", 64'(cpu_rst_n), 64'd0);
    chk("midrun in_ready", 64'(in_ready), 64'd1);
    repeat (40) @(negedge clk);
    #1;
    chk("midrun no done", 64'(n_done - b_done), 64'd0);
    rst_n = 1'b1;
    dq = {8'h11, 8'h22, 8'h33};
    run_load("after reset", 8'h49, 32'h20, dq, nw, eo);

    dq = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load("range", 8'h49, 32'hFE, dq, nw, eo);
    chk("range nw", 64'(nw), 64'd2);
    do_reset();
    dq = {8'h01, 8'h02};
    run_load("badcmd", 8'h55, 32'h0, dq, nw, eo);
    chk("badcmd nw", 64'(nw), 64'd0);
    chk("badcmd busy", 64'(busy), 64'd1);
    do_reset();
    #1;
    chk("post reset err", 64'(err), 64'd0);
    chk("one strobe", 64'(n_both), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_boot_loader.md
Name: mips_boot_loader

Overview:
- Byte-stream boot loader for the MIPS processor.
- Receives framed commands over a valid/ready byte interface and writes them byte-by-byte into the big-endian, byte-addressed instruction and data memories.
- Then releases the processor from reset at a chosen PC for a programmed number of cycles.
- Replaces hand-poked memory initialisation and fixed simulation run lengths; sits between the host/UART side and the processor top.

Parameters:
ADDR_BYTES, 4, byte count of address and PC fields; address width AW = 8*ADDR_BYTES
LEN_BYTES, 2, byte count of the payload length field
CYC_BYTES, 4, byte count of the run-cycle count field
IMEM_SIZE, 256, instruction memory size in bytes; legal addresses 0..IMEM_SIZE-1
DMEM_SIZE, 256, data memory size in bytes; legal addresses 0..DMEM_SIZE-1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input byte valid
in_ready  out  1  loader can accept a byte
in_data  in  8  input byte
imem_we  out  1  instruction memory byte write strobe
dmem_we  out  1  data memory byte write strobe
mem_addr  out  AW  byte address for the active write strobe
mem_wdata  out  8  byte to write
pc_load  out  1  one-cycle pulse: processor loads pc_init
pc_init  out  AW  start PC
cpu_rst_n  out  1  processor reset, active-low; low whenever the CPU is not running
run_done  out  1  one-cycle pulse at end of a run
err  out  1  sticky protocol/range error
busy  out  1  high in every state except IDLE

Behaviour:
- Transfer: a byte transfers on a rising clk edge when in_valid && in_ready. in_valid gaps mid-frame are legal and change nothing.
- Reset (async): state IDLE. All outputs 0 except in_ready=1. cpu_rst_n=0.
- Frames. All multi-byte fields are big-endian.
  - 0x49 'I': ADDR, LEN, then LEN payload bytes, written to imem.
  - 0x44 'D': same format, written to dmem.
  - 0x47 'G': PC (ADDR_BYTES), CYC (CYC_BYTES).
  - Any other command byte goes to ERR.
- States: IDLE, HDR_ADDR, HDR_LEN, DATA, GO_PC, GO_CYC, RUN, ERR.
  - A byte counter sequences the header fields.
  - in_ready=1 in IDLE/HDR_*/DATA/GO_*; 0 in RUN and ERR.
- Write latency: payload byte k (k=0..LEN-1) accepted at edge N produces, for exactly the cycle after edge N:
  - imem_we or dmem_we = 1
  - mem_addr = ADDR + k (modulo 2^AW)
  - mem_wdata = that byte
  - At most one strobe is high per cycle.
- LEN=0: return to IDLE after the last LEN byte; no writes.
- Range check: a payload byte whose address is >= IMEM_SIZE or DMEM_SIZE (per target) is not written.
  - The state moves to ERR.
  - Bytes earlier in the frame remain written.
- ERR: err=1, in_ready=0. Only rst_n exits.
- GO, on the edge accepting the last CYC byte:
  - CYC=0: run_done pulses the next cycle, then IDLE; no pc_load, cpu_rst_n stays 0.
  - CYC>0: pc_load=1 and pc_init=PC for the next cycle. cpu_rst_n=1 starting the cycle after that, for exactly CYC cycles. cpu_rst_n then returns to 0, run_done pulses that same cycle, and the state returns to IDLE.
  - pc_init holds its value until the next GO.
- Run counter: CYC_BYTES*8 bits wide, down-counting, no wrap. Maximum CYC = 2^(8*CYC_BYTES)-1.
- Reset mid-frame or mid-run: immediate return to reset values. cpu_rst_n drops asynchronously. A partial frame is discarded; bytes already written stay in memory.

Decomposition:
- Package mips_boot_pkg holds:
  - command byte constants CMD_IMEM=8'h49, CMD_DMEM=8'h44, CMD_GO=8'h47
  - state enum boot_state_t
- Sub-module mips_boot_field_shift: accumulates big-endian fields.
  - Parametrised byte count; shift-in enable; done flag.
  - Instantiated for address/PC, length, and cycle count.

Test Plan:
- IMEM load: stream 49 00 00 00 00 00 04 0C 00 00 05 -> four imem_we cycles at mem_addr 0,1,2,3 with data 0C,00,00,05. dmem_we stays 0, err=0.
- DMEM load with backpressure: stream 44 00 00 00 04 00 04 00 00 00 28, in_valid low every other cycle -> dmem_we at addr 4..7 with data 00,00,00,28; byte order and count unchanged.
- GO: 47 00 00 00 00 00 00 00 1E ->
  - pc_load pulse with pc_init=0
  - cpu_rst_n high exactly 30 cycles, then run_done pulse in the cycle cpu_rst_n falls
  - in_ready=0 throughout, state IDLE after
- GO with CYC=0 -> run_done pulse, no pc_load, cpu_rst_n never high.
- Range/protocol errors:
  - 49 00 00 00 FE 00 04 AA BB CC DD with IMEM_SIZE=256 -> writes at FE, FF only, then err=1 and in_ready=0.
  - Separately, command byte 55 -> err=1 with no writes.
- Reset mid-run: assert rst_n=0 at cycle 10 of a 30-cycle GO -> cpu_rst_n=0 immediately, no run_done. After release, an IMEM frame is accepted normally.
